instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/kgp_fetch_pkg.sv | 18 +
 rtl/fetch_watchdog.sv | 30 +++
 rtl/instruction_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its watchdog.
package kgp_fetch_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DELIVER = 3'd2,
        S_WAIT_PC = 3'd3,
        S_HALTED  = 3'd4
    } fetch_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive FETCH cycles without an acknowledge; expired flags the
// last permitted cycle so the FSM can leave FETCH on the following edge.
module fetch_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] r_count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign expired = enable && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch unit: fetches at pc, hands the word to
// decode, then waits for the branch unit to commit the next pc.
module instruction_fetch_unit
    import kgp_fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] pc_next,
    input  logic              pc_load,
    input  logic              halt,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [WORD_W-1:0] instr_count
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] r_instr_count;
    logic              r_imem_req;
    logic              r_instr_valid;
    logic              r_fault;
    logic [1:0]        r_fault_code;
    logic              r_halt_pend;

    logic              w_halt_now;
    logic              w_aligned;
    logic              w_handshake;
    logic              w_commit_pc;
    logic              w_wd_clear;
    logic              w_wd_enable;
    logic              w_wd_expired;
    logic [1:0]        w_fault_code_set;

    // A halt arriving in the decision cycle itself counts, hence the OR with the raw input.
    assign w_halt_now  = r_halt_pend | halt;
    assign w_aligned   = (pc_next[1:0] == 2'b00);
    assign w_handshake = (r_state == S_DELIVER) && instr_ready;
    assign w_commit_pc = (r_state == S_WAIT_PC) && !w_halt_now && pc_load && w_aligned;
    assign w_wd_enable = (r_state == S_FETCH) && !imem_ack;
    assign w_wd_clear  = (w_state_next == S_FETCH) && (r_state != S_FETCH);

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expired (w_wd_expired)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_fault_code_set = FAULT_NONE;
        if (w_wd_expired) begin
            w_fault_code_set = FAULT_TIMEOUT;
        end else if ((r_state == S_WAIT_PC) && !w_halt_now && pc_load && !w_aligned) begin
            w_fault_code_set = FAULT_MISALIGN;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                w_state_next = w_halt_now ? S_HALTED : S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_state_next = S_DELIVER;
                end else if (w_wd_expired) begin
                    w_state_next = S_HALTED;
                end
            end
            S_DELIVER: begin
                if (instr_ready) begin
                    w_state_next = S_WAIT_PC;
                end
            end
            S_WAIT_PC: begin
                if (w_halt_now) begin
                    w_state_next = S_HALTED;
                end else if (pc_load) begin
                    w_state_next = w_aligned ? S_FETCH : S_HALTED;
                end
            end
            S_HALTED: begin
                w_state_next = S_HALTED;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_code  <= FAULT_NONE;
            r_instr_count <= '0;
            r_halt_pend   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_imem_req    <= (w_state_next == S_FETCH);
            r_instr_valid <= (w_state_next == S_DELIVER);
            if (halt) begin
                r_halt_pend <= 1'b1;
            end
            if ((r_state == S_FETCH) && imem_ack) begin
                r_instr <= imem_rdata;
            end
            if (w_handshake) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
            if (w_commit_pc) begin
                r_pc <= pc_next;
            end
            // Only the first fault is recorded; later ones leave the code untouched.
            if ((w_fault_code_set != FAULT_NONE) && !r_fault) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_fault_code_set;
            end
        end
    end

    assign pc          = r_pc;
    assign imem_addr   = r_pc;
    assign imem_req    = r_imem_req;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: fetched words are queued on
// ack and compared when decode accepts them; control behaviour is checked directly.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_0040;
    localparam int          TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_load;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] instr_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_count;

    instruction_fetch_unit #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_next     (pc_next),
        .pc_load     (pc_load),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fault       (fault),
        .fault_code  (fault_code),
        .instr_count (instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_pc"},          pc,                 RST_PC);
        check({pfx, "_addr"},        imem_addr,          RST_PC);
        check({pfx, "_req"},         {31'd0, imem_req},  32'd0);
        check({pfx, "_instr"},       instr,              32'd0);
        check({pfx, "_valid"},       {31'd0, instr_valid}, 32'd0);
        check({pfx, "_fault"},       {31'd0, fault},     32'd0);
        check({pfx, "_fault_code"},  {30'd0, fault_code}, 32'd0);
        check({pfx, "_count"},       instr_count,        32'd0);
    endtask

    // Reset asserted on a falling edge; outputs must be at reset values at once.
    task automatic do_reset(input bit expect_fetch);
        @(negedge clk);
        reset = 1'b1;
        pc_load = 1'b0; pc_next = '0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        #1;
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b0;
        exp_pc = RST_PC;
        exp_count = '0;
        exp_q.delete();
        check("idle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("post_idle_req", {31'd0, imem_req}, {31'd0, expect_fetch});
        if (expect_fetch) check("post_idle_addr", imem_addr, RST_PC);
    endtask

    // Entered with imem_req high; acks after 'delay' request cycles.
    task automatic fetch_word(input logic [31:0] rdata, input int delay);
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("fetch_req_hold", {31'd0, imem_req}, 32'd1);
        end
        imem_ack = 1'b1;
        imem_rdata = rdata;
        exp_q.push_back(rdata);
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = '0;
        check("ack_valid", {31'd0, instr_valid}, 32'd1);
        check("ack_req_drop", {31'd0, imem_req}, 32'd0);
    endtask

    // Holds decode off for 'stall' cycles; optionally pokes pc_load and imem_ack,
    // both of which must be ignored while delivering.
    task automatic deliver(input int stall, input bit inject);
        logic [31:0] held;
        held = instr;
        for (int i = 0; i < stall; i++) begin
            check("bp_valid", {31'd0, instr_valid}, 32'd1);
            check("bp_instr", instr, held);
            check("bp_count", instr_count, exp_count);
            if (inject && i == 1) begin
                pc_load = 1'b1; pc_next = 32'h0000_0300;
            end else if (inject && i == 2) begin
                pc_load = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
            end else begin
                pc_load = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
            end
            @(negedge clk);
        end
        pc_load = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        check("dlv_valid", {31'd0, instr_valid}, 32'd1);
        check("dlv_pc_hold", pc, exp_pc);
        if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else check("sb_instr", instr, exp_q.pop_front());
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        exp_count = exp_count + 32'd1;
        check("dlv_valid_drop", {31'd0, instr_valid}, 32'd0);
        check("dlv_count", instr_count, exp_count);
    endtask

    task automatic load_pc(input logic [31:0] addr);
        check("wait_req", {31'd0, imem_req}, 32'd0);
        pc_load = 1'b1;
        pc_next = addr;
        @(negedge clk);
        pc_load = 1'b0;
        exp_pc = addr;
        check("load_req", {31'd0, imem_req}, 32'd1);
        check("load_addr", imem_addr, addr);
        check("load_pc", pc, addr);
    endtask

    initial begin
        int n;
        reset = 1'b0; halt = 1'b0; pc_load = 1'b0; pc_next = '0;
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        exp_pc = RST_PC; exp_count = '0;

        // Sequential fetch with a two-cycle memory latency.
        do_reset(1'b1);
        fetch_word(32'h1234_5678, 2);
        deliver(0, 1'b0);
        load_pc(32'h0000_0004);

        // Backpressure with stray pc_load / imem_ack that must be ignored.
        fetch_word(32'hDEAD_BEEF, 0);
        deliver(5, 1'b1);
        load_pc(32'h0000_0008);

        // Asynchronous reset in the middle of a FETCH cycle, late ack during IDLE.
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b0;
        exp_pc = RST_PC; exp_count = '0; exp_q.delete();
        imem_ack = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        check("midrst_idle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = '0;
        check("midrst_req", {31'd0, imem_req}, 32'd1);
        check("midrst_addr", imem_addr, RST_PC);
        check("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check("midrst_instr", instr, 32'd0);

        // Misaligned branch target.
        fetch_word(32'hCAFE_F00D, 1);
        deliver(0, 1'b0);
        pc_load = 1'b1;
        pc_next = 32'h0000_0102;
        @(negedge clk);
        pc_load = 1'b0;
        check("mis_fault", {31'd0, fault}, 32'd1);
        check("mis_code", {30'd0, fault_code}, 32'd1);
        check("mis_pc", pc, exp_pc);
        check("mis_req", {31'd0, imem_req}, 32'd0);
        pc_load = 1'b1;
        pc_next = 32'h0000_0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pc_load = 1'b0;
            check("mis_halted_req", {31'd0, imem_req}, 32'd0);
            check("mis_halted_pc", pc, exp_pc);
            check("mis_halted_fault", {31'd0, fault}, 32'd1);
        end

        // Watchdog timeout: memory never acknowledges.
        do_reset(1'b1);
        n = 0;
        while (imem_req === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        check("to_cycles", n, TIMEOUT);
        check("to_fault", {31'd0, fault}, 32'd1);
        check("to_code", {30'd0, fault_code}, 32'd2);
        check("to_pc", pc, RST_PC);
        imem_ack = 1'b1;
        imem_rdata = 32'h7777_7777;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        check("to_late_ack_valid", {31'd0, instr_valid}, 32'd0);
        check("to_late_ack_req", {31'd0, imem_req}, 32'd0);
        check("to_code_hold", {30'd0, fault_code}, 32'd2);

        // Halt and pc_load in the same WAIT_PC cycle: halt wins.
        do_reset(1'b1);
        fetch_word(32'h0000_0013, 3);
        deliver(0, 1'b0);
        halt = 1'b1;
        pc_load = 1'b1;
        pc_next = 32'h0000_0008;
        @(negedge clk);
        halt = 1'b0;
        pc_load = 1'b0;
        check("race_pc", pc, RST_PC);
        check("race_fault", {31'd0, fault}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("race_req", {31'd0, imem_req}, 32'd0);
            @(negedge clk);
        end

        // Halt during DELIVER: delivery completes, then WAIT_PC halts without fetching.
        do_reset(1'b1);
        fetch_word(32'hA5A5_0001, 0);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        deliver(2, 1'b0);
        pc_load = 1'b1;
        pc_next = 32'h0000_0020;
        @(negedge clk);
        pc_load = 1'b0;
        check("hpend_req", {31'd0, imem_req}, 32'd0);
        check("hpend_pc", pc, RST_PC);
        @(negedge clk);
        check("hpend_req2", {31'd0, imem_req}, 32'd0);
        check("hpend_count", instr_count, 32'd1);

        // Halt present when leaving reset: IDLE goes straight to HALTED.
        halt = 1'b1;
        do_reset(1'b0);
        halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_halt_req", {31'd0, imem_req}, 32'd0);
        end
        check("idle_halt_pc", pc, RST_PC);

        check("sb_drain", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
